// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Bundle of the rename/allocate, writeback and commit signals
//               between the reorder buffer and its neighbours.
//               master : driven by rename / execution side (testbench)
//               slave  : the reorder buffer itself
//               Optional macro ROB_EXCEPTION_EN adds the wb_exc signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if #(
    parameter int NUM_ENTRIES = 16,
    parameter int A_REG_W     = 5,
    parameter int P_REG_W     = 6,
    parameter int TAG_W       = $clog2(NUM_ENTRIES)
);
    // allocate (rename side)
    logic               alloc_valid;
    logic               alloc_ready;
    logic               alloc_has_dest;
    logic [A_REG_W-1:0] alloc_dest_arch;
    logic [P_REG_W-1:0] alloc_p_new;
    logic [P_REG_W-1:0] alloc_p_old;
    logic [TAG_W-1:0]   alloc_tag;
    // writeback (execution side)
    logic               wb_valid;
    logic [TAG_W-1:0]   wb_tag;
`ifdef ROB_EXCEPTION_EN
    logic               wb_exc;
`endif
    // commit / status
    logic               commit_valid;
    logic [A_REG_W-1:0] commit_dest_arch;
    logic [P_REG_W-1:0] commit_p_new;
    logic [P_REG_W-1:0] commit_p_old;
    logic               flush;
    logic               empty;

    modport master (
`ifdef ROB_EXCEPTION_EN
        output wb_exc,
`endif
        output alloc_valid, alloc_has_dest, alloc_dest_arch, alloc_p_new,
               alloc_p_old, wb_valid, wb_tag,
        input  alloc_ready, alloc_tag, commit_valid, commit_dest_arch,
               commit_p_new, commit_p_old, flush, empty
    );

    modport slave (
`ifdef ROB_EXCEPTION_EN
        input  wb_exc,
`endif
        input  alloc_valid, alloc_has_dest, alloc_dest_arch, alloc_p_new,
               alloc_p_old, wb_valid, wb_tag,
        output alloc_ready, alloc_tag, commit_valid, commit_dest_arch,
               commit_p_new, commit_p_old, flush, empty
    );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Circular in-order reorder buffer. Entries are allocated at
//               the tail by rename, marked done out of order by writeback,
//               and retired in program order (one per cycle) from the head.
//               Retirement returns the previous physical mapping to the free
//               list via commit_p_old (0 when nothing is to be freed).
// Ports       : clk, rst (synchronous, active high)
//               rob (reorder_buffer_if.slave): alloc_*, wb_*, commit_*,
//               flush, empty
// Macro       : ROB_EXCEPTION_EN - stores a per-entry exception bit; an
//               excepting head flushes the whole buffer instead of retiring.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int NUM_ENTRIES = 16,
    parameter int A_REG_W     = 5,
    parameter int P_REG_W     = 6,
    parameter int TAG_W       = $clog2(NUM_ENTRIES)
) (
    input wire logic         clk,
    input wire logic         rst,
    reorder_buffer_if.slave  rob
);

    localparam logic [TAG_W:0]   c_full_count = (TAG_W+1)'(NUM_ENTRIES);
    localparam logic [TAG_W:0]   c_count_one  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] c_tag_one    = TAG_W'(1);

    // per-entry state
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [NUM_ENTRIES-1:0] r_done;
    logic [NUM_ENTRIES-1:0] r_has_dest;
    logic [A_REG_W-1:0]     r_dest_arch [NUM_ENTRIES];
    logic [P_REG_W-1:0]     r_p_new     [NUM_ENTRIES];
    logic [P_REG_W-1:0]     r_p_old     [NUM_ENTRIES];

    logic [TAG_W-1:0]       r_head;
    logic [TAG_W-1:0]       r_tail;
    logic [TAG_W:0]         r_count;

    logic                   r_commit_valid;
    logic [A_REG_W-1:0]     r_commit_dest_arch;
    logic [P_REG_W-1:0]     r_commit_p_new;
    logic [P_REG_W-1:0]     r_commit_p_old;

    logic                   w_head_done;
    logic                   w_head_exc;
    logic                   w_retire;
    logic                   w_flush;
    logic                   w_full;
    logic                   w_alloc;
    logic                   w_wb_hit;

    assign w_head_done = r_valid[r_head] && r_done[r_head];
    assign w_full      = (r_count == c_full_count);
    assign w_wb_hit    = rob.wb_valid && r_valid[rob.wb_tag];

`ifdef ROB_EXCEPTION_EN
    logic [NUM_ENTRIES-1:0] r_exc;
    logic                   r_flush;
    assign w_head_exc = r_exc[r_head];
    assign rob.flush  = r_flush;
`else
    assign w_head_exc = 1'b0;
    assign rob.flush  = 1'b0;
`endif

    assign w_retire = w_head_done && !w_head_exc;
    assign w_flush  = w_head_done && w_head_exc;

    // Readiness deliberately ignores a same-cycle retirement so the ready
    // path stays short; an excepting head also blocks allocation because
    // that edge wipes the buffer.
    assign rob.alloc_ready = !w_full && !w_flush;
    assign w_alloc         = rob.alloc_valid && !w_full && !w_flush;
    assign rob.alloc_tag   = r_tail;
    assign rob.empty       = (r_count == '0);

    assign rob.commit_valid     = r_commit_valid;
    assign rob.commit_dest_arch = r_commit_dest_arch;
    assign rob.commit_p_new     = r_commit_p_new;
    assign rob.commit_p_old     = r_commit_p_old;

    // Control state: valid/done bits, pointers, occupancy, commit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid            <= '0;
            r_done             <= '0;
            r_head             <= '0;
            r_tail             <= '0;
            r_count            <= '0;
            r_commit_valid     <= 1'b0;
            r_commit_dest_arch <= '0;
            r_commit_p_new     <= '0;
            r_commit_p_old     <= '0;
`ifdef ROB_EXCEPTION_EN
            r_exc              <= '0;
            r_flush            <= 1'b0;
`endif
        end else if (w_flush) begin
            r_valid        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
`ifdef ROB_EXCEPTION_EN
            r_flush        <= 1'b1;
`endif
        end else begin
`ifdef ROB_EXCEPTION_EN
            r_flush <= 1'b0;
`endif
            r_commit_valid <= w_retire;

            // A writeback can only hit a valid entry, so it never aliases the
            // (invalid) tail slot being allocated this cycle.
            if (w_wb_hit) begin
                r_done[rob.wb_tag] <= 1'b1;
`ifdef ROB_EXCEPTION_EN
                r_exc[rob.wb_tag]  <= rob.wb_exc;
`endif
            end

            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
`ifdef ROB_EXCEPTION_EN
                r_exc[r_tail]   <= 1'b0;
`endif
                r_tail          <= r_tail + c_tag_one;
            end

            if (w_retire) begin
                r_valid[r_head]    <= 1'b0;
                r_head             <= r_head + c_tag_one;
                r_commit_dest_arch <= r_dest_arch[r_head];
                r_commit_p_new     <= r_p_new[r_head];
                // Nothing to free for no-dest instructions or writes to r0.
                r_commit_p_old     <= (r_has_dest[r_head] && (r_dest_arch[r_head] != '0))
                                      ? r_p_old[r_head] : '0;
            end

            if (w_alloc && !w_retire) begin
                r_count <= r_count + c_count_one;
            end else if (w_retire && !w_alloc) begin
                r_count <= r_count - c_count_one;
            end
        end
    end

    // Payload storage: written only on allocation, no reset needed.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_has_dest[r_tail]  <= rob.alloc_has_dest;
            r_dest_arch[r_tail] <= rob.alloc_dest_arch;
            r_p_new[r_tail]     <= rob.alloc_p_new;
            r_p_old[r_tail]     <= rob.alloc_p_old;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer. Expected commits are
//               queued at allocation and compared when commit_valid pulses.
//               Exception-flush checks are built only with ROB_EXCEPTION_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int N  = 16;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.NUM_ENTRIES(N), .A_REG_W(AW), .P_REG_W(PW), .TAG_W(TW)) bus ();

    reorder_buffer #(.NUM_ENTRIES(N), .A_REG_W(AW), .P_REG_W(PW), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .rob (bus)
    );

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [PW-1:0] pnew;
        logic [PW-1:0] pold;
    } commit_t;

    commit_t        sb[$];
    logic [TW-1:0]  pend[$];
    int             total   = 0;
    int             bad     = 0;
    int             commits = 0;
    logic [TW-1:0]  exp_tail = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, score any commit, release strobes.
    task automatic tick();
        commit_t e;
        @(posedge clk);
        #1;
        if (bus.commit_valid !== 1'b0) begin
            commits++;
            if (sb.size() == 0) begin
                check("commit_unexpected", 32'(bus.commit_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("commit_dest",  32'(bus.commit_dest_arch), 32'(e.dest));
                check("commit_pnew",  32'(bus.commit_p_new),     32'(e.pnew));
                check("commit_pold",  32'(bus.commit_p_old),     32'(e.pold));
            end
        end
        bus.alloc_valid = 1'b0;
        bus.wb_valid    = 1'b0;
`ifdef ROB_EXCEPTION_EN
        bus.wb_exc      = 1'b0;
`endif
    endtask

    task automatic drive_alloc(input bit hd, input logic [AW-1:0] d,
                               input logic [PW-1:0] pn, input logic [PW-1:0] po,
                               input bit exp_acc);
        commit_t e;
        bus.alloc_valid     = 1'b1;
        bus.alloc_has_dest  = hd;
        bus.alloc_dest_arch = d;
        bus.alloc_p_new     = pn;
        bus.alloc_p_old     = po;
        check("alloc_ready", 32'(bus.alloc_ready), 32'(exp_acc));
        if (exp_acc) begin
            check("alloc_tag", 32'(bus.alloc_tag), 32'(exp_tail));
            e.dest = d;
            e.pnew = pn;
            e.pold = (hd && d != '0) ? po : '0;
            sb.push_back(e);
            pend.push_back(exp_tail);
            exp_tail++;
        end
    endtask

    task automatic drive_wb(input logic [TW-1:0] t, input bit exc);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = t;
`ifdef ROB_EXCEPTION_EN
        bus.wb_exc   = exc;
`else
        if (exc) $display("note: wb_exc ignored in this build");
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        pend.delete();
        tick();
        tick();
        rst = 1'b0;
        exp_tail = '0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && sb.size() != 0; k++) tick();
        check(tag, 32'(sb.size()), 32'd0);
        check({tag, "_empty"}, 32'(bus.empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int idx;
        bit hd;
        logic [AW-1:0] rd;
        logic [PW-1:0] rpn, rpo;

        bus.alloc_valid = 1'b0;
        bus.alloc_has_dest = 1'b0;
        bus.alloc_dest_arch = '0;
        bus.alloc_p_new = '0;
        bus.alloc_p_old = '0;
        bus.wb_valid = 1'b0;
        bus.wb_tag = '0;
`ifdef ROB_EXCEPTION_EN
        bus.wb_exc = 1'b0;
`endif

        // ---- reset state
        do_reset();
        check("rst_commit_valid", 32'(bus.commit_valid),     32'd0);
        check("rst_commit_dest",  32'(bus.commit_dest_arch), 32'd0);
        check("rst_commit_pold",  32'(bus.commit_p_old),     32'd0);
        check("rst_flush",        32'(bus.flush),            32'd0);
        check("rst_alloc_ready",  32'(bus.alloc_ready),      32'd1);
        check("rst_alloc_tag",    32'(bus.alloc_tag),        32'd0);
        check("rst_empty",        32'(bus.empty),            32'd1);

        // ---- single instruction, minimum latency
        drive_alloc(1, 5'd3, 6'd32, 6'd3, 1);
        tick();
        check("single_not_empty", 32'(bus.empty), 32'd0);
        c0 = commits;
        drive_wb(4'd0, 0);
        tick();
        check("single_no_early_commit", 32'(commits), 32'(c0));
        tick();
        check("single_commit_valid", 32'(bus.commit_valid), 32'd1);
        check("single_empty", 32'(bus.empty), 32'd1);
        tick();
        check("single_pulse_once", 32'(bus.commit_valid), 32'd0);

        // ---- out-of-order completion, in-order retire; p_old forcing
        do_reset();
        drive_alloc(1, 5'd7, 6'd33, 6'd7,  1); tick();
        drive_alloc(0, 5'd9, 6'd34, 6'd12, 1); tick();
        drive_alloc(1, 5'd0, 6'd35, 6'd0,  1); tick();
        pend.delete();
        c0 = commits;
        drive_wb(4'd2, 0); tick();
        drive_wb(4'd1, 0); tick();
        tick();
        check("ooo_hold", 32'(commits), 32'(c0));
        drive_wb(4'd0, 0); tick();
        tick(); check("ooo_commit0", 32'(bus.commit_valid), 32'd1);
        tick(); check("ooo_commit1", 32'(bus.commit_valid), 32'd1);
        tick(); check("ooo_commit2", 32'(bus.commit_valid), 32'd1);
        check("ooo_count", 32'(commits), 32'(c0 + 3));
        tick(); check("ooo_done", 32'(bus.commit_valid), 32'd0);

        // ---- fill to capacity, reject 17th, retire+alloc on full
        do_reset();
        for (int i = 0; i < N; i++) begin
            drive_alloc(1, AW'(i + 1), PW'(i + 20), PW'(i + 1), 1);
            tick();
        end
        check("full_ready", 32'(bus.alloc_ready), 32'd0);
        check("full_tag_wrap", 32'(bus.alloc_tag), 32'd0);
        drive_alloc(1, 5'd30, 6'd60, 6'd30, 0);
        tick();
        check("full_17th_tag", 32'(bus.alloc_tag), 32'd0);
        check("full_17th_ready", 32'(bus.alloc_ready), 32'd0);
        drive_wb(4'd0, 0);
        tick();
        c0 = commits;
        drive_alloc(1, 5'd31, 6'd61, 6'd31, 0);
        tick();
        check("full_retire_happens", 32'(commits), 32'(c0 + 1));
        check("full_no_alloc_tag", 32'(bus.alloc_tag), 32'd0);
        drive_alloc(1, 5'd31, 6'd61, 6'd31, 1);
        tick();
        check("full_again_ready", 32'(bus.alloc_ready), 32'd0);
        pend.delete();
        for (int i = 1; i <= N; i++) begin
            drive_wb(TW'(i), 0);
            tick();
        end
        drain("full_drain");

        // ---- random sustained traffic
        for (int c = 0; c < 300; c++) begin
            if (pend.size() != 0 && $urandom_range(0, 2) != 0) begin
                idx = $urandom_range(0, pend.size() - 1);
                drive_wb(pend[idx], 0);
                pend.delete(idx);
            end
            if ($urandom_range(0, 3) != 0) begin
                hd  = 1'($urandom_range(0, 1));
                rd  = AW'($urandom_range(0, 31));
                rpn = PW'($urandom_range(0, 47));
                rpo = PW'($urandom_range(0, 47));
                if (sb.size() < N) drive_alloc(hd, rd, rpn, rpo, 1);
                else               drive_alloc(hd, rd, rpn, rpo, 0);
                if (sb.size() > N) pend.delete();
            end
            tick();
        end
        while (pend.size() != 0) begin
            drive_wb(pend.pop_front(), 0);
            tick();
        end
        drain("rand_drain");

        // ---- writeback to an invalid entry is ignored
        drive_wb(exp_tail + 4'd5, 0);
        tick();
        tick();
        check("badwb_no_commit", 32'(bus.commit_valid), 32'd0);
        check("badwb_empty", 32'(bus.empty), 32'd1);
        drive_alloc(1, 5'd4, 6'd44, 6'd4, 1); tick();
        drive_wb(exp_tail - 4'd1, 0); tick();
        drain("badwb_followup");

        // ---- reset mid-operation discards entries without commits
        drive_alloc(1, 5'd5, 6'd40, 6'd5, 1); tick();
        drive_alloc(1, 5'd6, 6'd41, 6'd6, 1); tick();
        drive_wb(exp_tail - 4'd2, 0); tick();
        rst = 1'b1;
        sb.delete();
        pend.delete();
        tick();
        rst = 1'b0;
        exp_tail = '0;
        check("midrst_commit", 32'(bus.commit_valid), 32'd0);
        tick();
        tick();
        check("midrst_empty", 32'(bus.empty), 32'd1);
        check("midrst_tag", 32'(bus.alloc_tag), 32'd0);
        check("midrst_flush", 32'(bus.flush), 32'd0);

`ifdef ROB_EXCEPTION_EN
        // ---- exception flush
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_alloc(1, AW'(i + 8), PW'(i + 36), PW'(i + 8), 1);
            tick();
        end
        drive_wb(4'd0, 1);
        tick();
        check("exc_ready_blocked", 32'(bus.alloc_ready), 32'd0);
        sb.delete();
        pend.delete();
        bus.alloc_valid = 1'b1;
        c0 = commits;
        tick();
        check("exc_flush", 32'(bus.flush), 32'd1);
        check("exc_no_commit", 32'(bus.commit_valid), 32'd0);
        check("exc_empty", 32'(bus.empty), 32'd1);
        check("exc_tag", 32'(bus.alloc_tag), 32'd0);
        tick();
        check("exc_flush_once", 32'(bus.flush), 32'd0);
        check("exc_commits", 32'(commits), 32'(c0));
        exp_tail = '0;
        drive_alloc(1, 5'd2, 6'd50, 6'd2, 1); tick();
        drive_wb(4'd0, 0); tick();
        drain("exc_recover");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order reorder buffer that sits directly downstream of the rename stage. Each renamed instruction is allocated an entry carrying its destination arch register, new physical register and previous physical mapping. Execution units mark entries complete out of order. Entries then retire in program order at one per cycle. At retirement the block returns the previous physical register to the rename stage's free list over `commit_p_old`.

## Interface
- `NUM_ENTRIES`, default 16: ROB depth; power of two, ≥ 4.
- `A_REG_W`, default 5: arch register index width (32 arch regs).
- `P_REG_W`, default 6: physical register index width (48 physical regs).
- `TAG_W`, default $clog2(NUM_ENTRIES): entry tag width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alloc_valid`  in  1  rename presents an instruction.
- `alloc_ready`  out  1  entry available; combinational `count != NUM_ENTRIES`, not gated by same-cycle commit.
- `alloc_has_dest`  in  1  instruction writes a register.
- `alloc_dest_arch`  in  A_REG_W  destination arch register.
- `alloc_p_new`  in  P_REG_W  newly allocated physical register.
- `alloc_p_old`  in  P_REG_W  previous mapping of `alloc_dest_arch`.
- `alloc_tag`  out  TAG_W  combinational tail pointer; tag assigned on handshake.
- `wb_valid`  in  1  an execution unit completes an instruction.
- `wb_tag`  in  TAG_W  entry being completed.
- `wb_exc`  in  1  completion raised an exception; present only with `ROB_EXCEPTION_EN`.
- `commit_valid`  out  1  registered; one-cycle pulse per retired entry.
- `commit_dest_arch`  out  A_REG_W  registered arch destination of the retired entry.
- `commit_p_new`  out  P_REG_W  registered; the retired entry's physical register.
- `commit_p_old`  out  P_REG_W  registered; physical register to free. Forced to 0 when the entry has no destination or its destination is arch r0.
- `flush`  out  1  registered exception flush pulse; tied 0 without `ROB_EXCEPTION_EN`.
- `empty`  out  1  combinational `count == 0`.

## Operation
- State per entry: valid, done, exc, has_dest, dest_arch, p_new, p_old. Pointers: `head`, `tail` (TAG_W, wrap naturally). Occupancy: `count`, TAG_W+1 bits.
- **Allocate** on `alloc_valid && alloc_ready`:
  - write the entry at `tail` with valid=1, done=0, exc=0;
  - advance `tail` by 1, modulo NUM_ENTRIES.
- **Writeback** on `wb_valid`:
  - if `entry[wb_tag].valid`, set done=1 and exc=`wb_exc`;
  - a writeback to an invalid entry is ignored, with no state change.
- **Retire** when `entry[head].valid && entry[head].done && !entry[head].exc`:
  - clear the entry's valid bit and advance `head`;
  - load the commit registers from the entry and set `commit_valid`=1 for the next cycle.
  - Otherwise `commit_valid`=0 next cycle.
- `count` update:
  - allocate and retire in the same cycle: unchanged;
  - allocate only: +1;
  - retire only: −1.
- Full (`count == NUM_ENTRIES`): `alloc_ready`=0, even if a retirement happens that cycle.
- Empty: no retirement.
- Writeback and retirement to the same entry in the same cycle cannot occur; done is registered, so retirement follows on a later edge.

## Timing
- Reset values: all valid/done/exc bits 0, `head`=`tail`=`count`=0. Outputs `commit_*`=0, `flush`=0, `alloc_ready`=1, `alloc_tag`=0, `empty`=1.
- Reset asserted mid-operation discards all entries at the next edge. No commits are emitted for the discarded entries.
- Minimum latency:
  - allocate at edge E0;
  - writeback accepted at edge E1 or later;
  - retirement at edge E1+1;
  - `commit_valid` high for the cycle following that edge.
- Throughput: one allocation and one retirement per cycle, sustained.

## Configuration
- `ROB_EXCEPTION_EN` defined:
  - the `wb_exc` port exists and the exc bit is stored;
  - when head is valid, done and exc, the block flushes at that edge instead of retiring: all valid bits are cleared, `head`=`tail`=`count`=0, `flush`=1 for the next cycle, and `commit_valid`=0.
  - An allocation in the flush cycle is dropped: `alloc_ready` is forced to 0 while head is excepting.
- `ROB_EXCEPTION_EN` undefined: there is no `wb_exc` port, the exc bit is always 0, and `flush` is constant 0.

## Test plan
- Reset, then allocate (dest r3, p_new 32, p_old 3), then writeback tag 0 -> `commit_valid` pulses once with dest 3, p_new 32, p_old 3; `empty` returns to 1.
- Allocate 16 entries with no writeback -> `alloc_ready`=0 and `alloc_tag`=0 wrapped; a 17th `alloc_valid` is not accepted and `count` stays 16.
- Allocate tags 0–2, write back in the order 2, 1, 0 -> no commit until tag 0 is done, then three consecutive commits in order 0, 1, 2.
- Allocation with dest r0 (p_old 0), or `has_dest`=0 -> it retires with `commit_valid`=1 and `commit_p_old`=0.
- Full ROB with head done: a same-cycle retire and `alloc_valid` -> retire occurs, no allocation; the allocation succeeds next cycle and `count` returns to 16.
- With `ROB_EXCEPTION_EN`: allocate 4 entries, write back tag 0 with `wb_exc`=1 -> `flush` pulses once, no commit is emitted, `empty`=1, and `alloc_tag`=0.
